wb_arbiter: RTL

Writeback arbiter that drives the register file's write port (`en`, `w_adr`, `w_data`). It merges two result sources into one write per cycle:
- the single-cycle execute path (port A, never stalled);
- the long-latency path (port B, loads/mul-div, valid/ready), buffered in a small FIFO.

It also keeps a 32-bit pending scoreboard of destinations issued to the long-latency path, so decode can stall on read-after-write hazards.

---
 rtl/wb_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the single-cycle execute result (A) and the buffered
// long-latency result (B) into one registered register-file write per cycle.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  input  logic [4:0]               a_rd,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_rd,
  input  logic [31:0]              b_data,
  input  logic                     iss_valid,
  input  logic [4:0]               iss_rd,
  output logic                     rf_en,
  output logic [4:0]               rf_adr,
  output logic [31:0]              rf_data,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     waw_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_en_q, rf_en_d;
  logic [4:0]    rf_adr_q, rf_adr_d;
  logic [31:0]   rf_data_q, rf_data_d;
  logic          src_b_q, src_b_d;
  logic [31:0]   pending_q, pending_d;
  logic          waw_err_q, waw_err_d;

  logic sel_a, sel_fifo, sel_byp, b_acc, push, pop;

  // Acceptance looks only at the registered count, never at a same-cycle pop.
  assign b_ready = (count_q < FULL);

  always_comb begin
    sel_a    = a_valid && (a_rd != 5'd0);
    b_acc    = b_valid && b_ready;
    sel_fifo = !sel_a && (count_q != '0);
    // Bypass only when the FIFO is empty, so B writes stay in acceptance order.
    sel_byp  = !sel_a && (count_q == '0) && b_acc && (b_rd != 5'd0);
    push     = b_acc && (b_rd != 5'd0) && !sel_byp;
    pop      = sel_fifo;
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rf_en_d   = 1'b0;
    rf_adr_d  = rf_adr_q;
    rf_data_d = rf_data_q;
    src_b_d   = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (sel_a) begin
      rf_en_d   = 1'b1;
      rf_adr_d  = a_rd;
      rf_data_d = a_data;
    end else if (sel_fifo) begin
      rf_en_d   = 1'b1;
      rf_adr_d  = mem_rd[rd_ptr_q];
      rf_data_d = mem_data[rd_ptr_q];
      src_b_d   = 1'b1;
    end else if (sel_byp) begin
      rf_en_d   = 1'b1;
      rf_adr_d  = b_rd;
      rf_data_d = b_data;
      src_b_d   = 1'b1;
    end
  end

  always_comb begin
    pending_d = pending_q;
    // Clear on the edge the register file commits a B write; a set applied after wins.
    if (rf_en_q && src_b_q) pending_d[rf_adr_q] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
    waw_err_d = waw_err_q || (sel_a && pending_q[a_rd]);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rf_en_q   <= 1'b0;
      rf_adr_q  <= 5'd0;
      rf_data_q <= 32'd0;
      src_b_q   <= 1'b0;
      pending_q <= 32'd0;
      waw_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rf_en_q   <= rf_en_d;
      rf_adr_q  <= rf_adr_d;
      rf_data_q <= rf_data_d;
      src_b_q   <= src_b_d;
      pending_q <= pending_d;
      waw_err_q <= waw_err_d;
    end
  end

  // NOTE: storage is not reset; entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr_q]   <= b_rd;
      mem_data[wr_ptr_q] <= b_data;
    end
  end

  assign rf_en      = rf_en_q;
  assign rf_adr     = rf_adr_q;
  assign rf_data    = rf_data_q;
  assign pending    = pending_q;
  assign fifo_count = count_q;
  assign waw_err    = waw_err_q;

endmodule
